// File: rtl/frame_read_sequencer.sv
// Frame read sequencer: arms the frame receiver, waits for capture (with timeout),
// then streams the captured frame out of the receiver buffer one 16-bit word at a time.
module frame_read_sequencer #(
  parameter int FRAME_LENGTH   = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  output logic        rx_go,
  input  logic        rx_busy,
  input  logic        rx_frame_complete,
  output logic [7:0]  rx_read_addr,
  input  logic [15:0] rx_read_data,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        idle,
  output logic        timeout_err,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT, ADDR, FETCH, PRESENT, DRAIN
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(FRAME_LENGTH / 2 - 1);
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [23:0] r_tmo_cnt;
  logic [7:0]  r_word_idx;
  logic [15:0] r_out_data;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_timeout_err;
  logic [15:0] r_frame_count;
  logic        r_start_pend;

  logic w_accept_start;
  logic w_tmo_hit;
  logic w_handshake;
  logic w_final_word;

  assign w_accept_start = start | r_start_pend;
  assign w_tmo_hit      = (r_tmo_cnt == TMO_LAST);
  assign w_handshake    = r_out_valid & out_ready;
  assign w_final_word   = (r_word_idx == LAST_IDX);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept_start || cont) w_next_state = ARM;
      ARM:     if (!rx_busy) w_next_state = WAIT;
      // Completion is tested first so a same-cycle timeout never discards a good frame.
      WAIT: begin
        if (rx_frame_complete) w_next_state = ADDR;
        else if (w_tmo_hit)    w_next_state = DRAIN;
      end
      ADDR:    w_next_state = FETCH;
      FETCH:   w_next_state = PRESENT;
      PRESENT: begin
        if (w_handshake) begin
          if (!w_final_word) w_next_state = ADDR;
          else if (cont)     w_next_state = ARM;
          else               w_next_state = IDLE;
        end
      end
      DRAIN:   if (rx_frame_complete) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_tmo_cnt     <= '0;
      r_word_idx    <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
      r_start_pend  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_next_state == ARM) begin
            r_start_pend <= 1'b0;
            if (w_accept_start) r_timeout_err <= 1'b0;
          end
        end
        ARM:  r_tmo_cnt <= '0;
        WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + 24'd1;
          if (rx_frame_complete) r_word_idx    <= '0;
          else if (w_tmo_hit)    r_timeout_err <= 1'b1;
        end
        FETCH: begin
          r_out_data  <= rx_read_data;
          r_out_valid <= 1'b1;
          r_out_last  <= w_final_word;
        end
        PRESENT: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_final_word) r_frame_count <= r_frame_count + 16'd1;
            else              r_word_idx    <= r_word_idx + 8'd1;
          end
        end
        // The receiver cannot be aborted, so a start seen here is remembered for IDLE.
        DRAIN: if (start) r_start_pend <= 1'b1;
        default: ;
      endcase
    end
  end

  // The word index only moves on entry to ADDR, so it doubles as the held read address.
  assign rx_read_addr = r_word_idx;
  assign rx_go        = (r_state == ARM) && !rx_busy;
  assign idle         = (r_state == IDLE);
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign timeout_err  = r_timeout_err;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_frame_read_sequencer.sv
// Directed bench for frame_read_sequencer: receiver model with synchronous read buffer,
// frame streaming, backpressure, timeout/drain, continuous mode and mid-stream reset.
module tb_frame_read_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cont;
  logic        rx_go;
  logic        rx_busy;
  logic        model_busy;
  logic        busy_force;
  logic        rx_frame_complete;
  logic [7:0]  rx_read_addr;
  logic [15:0] rx_read_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        idle;
  logic        timeout_err;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [256];
  int cpl_delay  = 20;
  int busy_hold  = 0;
  int rcv_cnt    = -1;
  int go_count   = 0;
  int go_busy_viol = 0;

  frame_read_sequencer #(
    .FRAME_LENGTH  (16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cont             (cont),
    .rx_go            (rx_go),
    .rx_busy          (rx_busy),
    .rx_frame_complete(rx_frame_complete),
    .rx_read_addr     (rx_read_addr),
    .rx_read_data     (rx_read_data),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .idle             (idle),
    .timeout_err      (timeout_err),
    .frame_count      (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rx_busy = model_busy | busy_force;

  // Receiver buffer: synchronous read, data valid one clock after the address.
  always @(posedge clk) rx_read_data <= mem[rx_read_addr];

  // Receiver: busy from the cycle after go, completion pulse cpl_delay cycles after go.
  initial begin
    model_busy        = 1'b0;
    rx_frame_complete = 1'b0;
    forever begin
      @(negedge clk);
      rx_frame_complete = 1'b0;
      if (rcv_cnt >= 0) begin
        rcv_cnt++;
        if (rcv_cnt == 1) model_busy = 1'b1;
        if (rcv_cnt == cpl_delay) rx_frame_complete = 1'b1;
        if (rcv_cnt == cpl_delay + 1 + busy_hold) begin
          model_busy = 1'b0;
          rcv_cnt    = -1;
        end
      end
      #1;
      if (rcv_cnt < 0 && rx_go === 1'b1) rcv_cnt = 0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rx_go === 1'b1) begin
        go_count++;
        if (rx_busy !== 1'b0) go_busy_viol++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish by 500000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [15:0] exp_word(input logic [7:0] base, input int i);
    logic [7:0] hi;
    hi = base + 8'(2 * i);
    return {hi, hi + 8'd1};
  endfunction

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 8; i++) mem[i] = exp_word(base, i);
  endtask

  // Leaves the caller in the cycle after the start pulse (ARM).
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Consumes nwords words; returns in the cycle after the final handshake.
  task automatic stream_check(input string tag, input int nwords, input bit bp,
                              input logic [7:0] base, input int budget, input int drop_cont_at,
                              input logic ready_after, output int first_valid, output int last_cyc);
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [15:0] held = '0;
    first_valid = -1;
    last_cyc    = -1;
    while (idx < nwords && cyc < budget) begin
      @(negedge clk);
      if (bp) out_ready = 1'($urandom_range(0, 1));
      #2;
      cyc++;
      if (stalled) begin
        check({tag, " valid held"}, out_valid, 1);
        check({tag, " data held"}, out_data, held);
      end
      if (out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (out_ready) begin
          check($sformatf("%s word %0d", tag, idx), out_data, exp_word(base, idx % 8));
          check($sformatf("%s last %0d", tag, idx), out_last, (idx % 8 == 7) ? 1 : 0);
          idx++;
          stalled  = 1'b0;
          last_cyc = cyc;
          if (idx == drop_cont_at) cont = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end else begin
        stalled = 1'b0;
      end
    end
    check({tag, " word count"}, idx, nwords);
    @(negedge clk);
    out_ready = ready_after;
    #2;
  endtask

  initial begin
    int fv;
    int lc;
    int g0;
    bit saw_valid;

    rst = 1'b1; start = 1'b0; cont = 1'b0; out_ready = 1'b1; busy_force = 1'b0;
    fill(8'h10);
    repeat (3) tick();
    check("reset idle", idle, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_last", out_last, 0);
    check("reset rx_go", rx_go, 0);
    check("reset rx_read_addr", rx_read_addr, 0);
    check("reset out_data", out_data, 0);
    check("reset frame_count", frame_count, 0);
    check("reset timeout_err", timeout_err, 0);

    // Basic frame, start in the very first cycle out of reset.
    rst = 1'b0;
    pulse_start();
    check("basic rx_go", rx_go, 1);
    check("basic not idle", idle, 0);
    stream_check("basic", 8, 1'b0, 8'h10, 200, -1, 1'b1, fv, lc);
    check("basic first valid cycle", fv, 23);
    check("basic last handshake cycle", lc, 44);
    check("basic idle after", idle, 1);
    check("basic frame_count", frame_count, 1);
    check("basic out_valid low", out_valid, 0);
    check("basic addr held", rx_read_addr, 7);

    // Backpressure with pseudo-random ready.
    fill(8'h40);
    pulse_start();
    check("bp rx_go", rx_go, 1);
    stream_check("bp", 8, 1'b1, 8'h40, 600, -1, 1'b1, fv, lc);
    check("bp idle after", idle, 1);
    check("bp frame_count", frame_count, 2);

    // Timeout: completion arrives at 150, limit is 100.
    cpl_delay = 150;
    saw_valid = 1'b0;
    pulse_start();
    check("t1 rx_go", rx_go, 1);
    for (int i = 1; i <= 151; i++) begin
      tick();
      if (out_valid !== 1'b0) saw_valid = 1'b1;
      if (i == 100) check("t1 err before limit", timeout_err, 0);
      if (i == 101) check("t1 err set", timeout_err, 1);
      if (i == 150) check("t1 still draining", idle, 0);
      if (i == 151) check("t1 idle after drain", idle, 1);
    end
    check("t1 no out_valid", saw_valid, 0);
    check("t1 frame_count unchanged", frame_count, 2);
    check("t1 err sticky", timeout_err, 1);

    // Second timeout; the start clears the flag, and a start in DRAIN is latched.
    pulse_start();
    check("t2 start clears err", timeout_err, 0);
    for (int i = 1; i <= 151; i++) begin
      tick();
      if (i == 101) check("t2 err set", timeout_err, 1);
      if (i == 120) start = 1'b1;
      if (i == 121) start = 1'b0;
      if (i == 151) check("t2 idle after drain", idle, 1);
    end
    cpl_delay = 20;
    fill(8'h70);
    tick();
    check("t2 latched start armed", idle, 0);
    check("t2 latched start go", rx_go, 1);
    check("t2 err cleared", timeout_err, 0);
    stream_check("t2", 8, 1'b0, 8'h70, 200, -1, 1'b1, fv, lc);
    check("t2 first valid cycle", fv, 23);
    check("t2 frame_count", frame_count, 3);

    // Completion in the same cycle as the timeout.
    cpl_delay = 100;
    fill(8'h22);
    pulse_start();
    stream_check("simul", 8, 1'b0, 8'h22, 300, -1, 1'b1, fv, lc);
    check("simul first valid cycle", fv, 103);
    check("simul no timeout", timeout_err, 0);
    check("simul frame_count", frame_count, 4);

    // Continuous mode: arm held off by busy, three frames, cont dropped mid third frame.
    cpl_delay  = 20;
    busy_hold  = 5;
    fill(8'hC0);
    busy_force = 1'b1;
    cont       = 1'b1;
    g0         = go_count;
    repeat (6) tick();
    check("cont held while busy", go_count - g0, 0);
    check("cont armed not idle", idle, 0);
    @(negedge clk);
    busy_force = 1'b0;
    #2;
    check("cont go after busy low", rx_go, 1);
    stream_check("cont", 24, 1'b0, 8'hC0, 600, 20, 1'b1, fv, lc);
    check("cont idle after", idle, 1);
    check("cont frame_count", frame_count, 7);
    check("cont go count", go_count - g0, 3);
    repeat (5) tick();
    check("cont no re-arm", go_count - g0, 3);
    busy_hold = 0;

    // Reset while word 4 is presented.
    fill(8'hA0);
    pulse_start();
    stream_check("rst pre", 4, 1'b0, 8'hA0, 200, -1, 1'b0, fv, lc);
    tick();
    tick();
    check("rst word4 valid", out_valid, 1);
    check("rst word4 data", out_data, exp_word(8'hA0, 4));
    tick();
    check("rst word4 stalled", out_valid, 1);
    rst = 1'b1;
    tick();
    check("rst out_valid", out_valid, 0);
    check("rst idle", idle, 1);
    check("rst frame_count", frame_count, 0);
    check("rst rx_read_addr", rx_read_addr, 0);
    check("rst out_data", out_data, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    pulse_start();
    check("rst restart go", rx_go, 1);
    stream_check("rst post", 8, 1'b0, 8'hA0, 200, -1, 1'b1, fv, lc);
    check("rst post frame_count", frame_count, 1);
    check("rst post idle", idle, 1);

    check("rx_go never with busy", go_busy_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
